// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, FSM state type and derivation helpers for the VGA driver.
// Also holds the colour-bar lookup used when VGA_TESTPAT_EN is defined.
package vga_timing_pkg;

   // 640x480@60 defaults
   localparam int unsigned DEF_H_SYNC  = 96;
   localparam int unsigned DEF_H_BACK  = 48;
   localparam int unsigned DEF_H_DISP  = 640;
   localparam int unsigned DEF_H_FRONT = 16;
   localparam int unsigned DEF_V_SYNC  = 2;
   localparam int unsigned DEF_V_BACK  = 33;
   localparam int unsigned DEF_V_DISP  = 480;
   localparam int unsigned DEF_V_FRONT = 10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      STOP_PEND = 2'd2
   } state_t;

   function automatic int unsigned timing_total(input int unsigned sync, input int unsigned back,
                                                input int unsigned disp, input int unsigned front);
      return sync + back + disp + front;
   endfunction

   // Bits needed to index 0..n-1, never less than one.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // {r,g,b} on/off for bars: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
      case (bar)
         3'd0:    return 3'b111;
         3'd1:    return 3'b110;
         3'd2:    return 3'b011;
         3'd3:    return 3'b010;
         3'd4:    return 3'b101;
         3'd5:    return 3'b100;
         3'd6:    return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, run/stop FSM and stage-0 sync/DE/request/channel-index decode.
// Optional VGA_TESTPAT_EN adds pat_on, latched at frame boundaries, which suppresses requests.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned CH_NUM  = 2,
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned H_DISP  = DEF_H_DISP,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK,
   parameter int unsigned V_DISP  = DEF_V_DISP,
   parameter int unsigned V_FRONT = DEF_V_FRONT
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
`ifdef VGA_TESTPAT_EN
   input  logic                        pat_on,
   output logic                        pat0,
   output logic [2:0]                  bar0,
`endif
   output logic                        hs0,
   output logic                        vs0,
   output logic                        de0,
   output logic                        sof0,
   output logic [cnt_bits(CH_NUM)-1:0] idx0,
   output logic [CH_NUM-1:0]           ch_req,
   output logic                        busy
);
   localparam int unsigned H_TOTAL = timing_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
   localparam int unsigned V_TOTAL = timing_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
   localparam int unsigned HW      = cnt_bits(H_TOTAL);
   localparam int unsigned VW      = cnt_bits(V_TOTAL);
   localparam int unsigned IW      = cnt_bits(CH_NUM);
   localparam int unsigned H_ACT   = H_SYNC + H_BACK;
   localparam int unsigned V_ACT   = V_SYNC + V_BACK;
   localparam int unsigned STRIP   = H_DISP / CH_NUM;

   state_t        state, state_nx;
   logic [HW-1:0] cnt_h;
   logic [VW-1:0] cnt_v;
   logic          h_end, frame_end, running, req_ok;
   logic [31:0]   h32, v32, act_h;

   assign h_end     = (cnt_h == HW'(H_TOTAL - 1));
   assign frame_end = h_end && (cnt_v == VW'(V_TOTAL - 1));
   assign running   = (state != IDLE);
   assign busy      = running;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (en) state_nx = RUN;
         RUN:       if (!en) state_nx = STOP_PEND;
         STOP_PEND: if (frame_end) state_nx = en ? RUN : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (!running) begin
         cnt_h <= '0;
         cnt_v <= '0;
      end else if (h_end) begin
         cnt_h <= '0;
         cnt_v <= (cnt_v == VW'(V_TOTAL - 1)) ? '0 : cnt_v + VW'(1);
      end else begin
         cnt_h <= cnt_h + HW'(1);
      end
   end

`ifdef VGA_TESTPAT_EN
   localparam int unsigned BAR = (H_DISP >= 8) ? H_DISP / 8 : 1;
   logic pat_mode;

   // Entering RUN and every frame wrap are the only places the mode may change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     pat_mode <= 1'b0;
      else if (!running || frame_end) pat_mode <= pat_on;
   end
   assign req_ok = !pat_mode;
   assign pat0   = pat_mode;
`else
   assign req_ok = 1'b1;
`endif

   always_comb begin
      // NOTE: each output is defaulted before any branch, so no path can infer a latch.
      hs0    = 1'b0;
      vs0    = 1'b0;
      de0    = 1'b0;
      sof0   = 1'b0;
      idx0   = '0;
      ch_req = '0;
`ifdef VGA_TESTPAT_EN
      bar0   = '0;
`endif
      h32    = 32'(cnt_h);
      v32    = 32'(cnt_v);
      act_h  = h32 - H_ACT;
      if (running) begin
         hs0  = (h32 < H_SYNC);
         vs0  = (v32 < V_SYNC);
         sof0 = (h32 == 0) && (v32 == 0);
         de0  = (h32 >= H_ACT) && (h32 < H_ACT + H_DISP) &&
                (v32 >= V_ACT) && (v32 < V_ACT + V_DISP);
      end
      if (de0) begin
         idx0 = IW'(act_h / STRIP);
`ifdef VGA_TESTPAT_EN
         bar0 = 3'(act_h / BAR);
`endif
         if (req_ok) ch_req = CH_NUM'(1) << idx0;
      end
   end

endmodule

// File: rtl/vga_multi_ch_driver.sv
// N-channel VGA driver: timing generator, RD_LAT-deep alignment line and registered pixel mux.
// Define VGA_TESTPAT_EN to add the pat_on colour-bar generator.
module vga_multi_ch_driver
   import vga_timing_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned CH_NUM  = 2,
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned H_SYNC  = DEF_H_SYNC,
   parameter int unsigned H_BACK  = DEF_H_BACK,
   parameter int unsigned H_DISP  = DEF_H_DISP,
   parameter int unsigned H_FRONT = DEF_H_FRONT,
   parameter int unsigned V_SYNC  = DEF_V_SYNC,
   parameter int unsigned V_BACK  = DEF_V_BACK,
   parameter int unsigned V_DISP  = DEF_V_DISP,
   parameter int unsigned V_FRONT = DEF_V_FRONT,
   parameter bit          HS_POL  = 1'b0,
   parameter bit          VS_POL  = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
`ifdef VGA_TESTPAT_EN
   input  logic                     pat_on,
`endif
   output logic [CH_NUM-1:0]        ch_req,
   input  logic [CH_NUM*DATA_W-1:0] ch_din,
   output logic                     vga_hsync,
   output logic                     vga_vsync,
   output logic                     vga_de,
   output logic [DATA_W-1:0]        vga_data,
   output logic                     frame_start,
   output logic                     busy
);
   localparam int unsigned IW = cnt_bits(CH_NUM);

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic          sof;
      logic [IW-1:0] idx;
`ifdef VGA_TESTPAT_EN
      logic          pat;
      logic [2:0]    bar;
`endif
   } stage_t;

   logic          hs0, vs0, de0, sof0;
   logic [IW-1:0] idx0;
   stage_t        s0, sd;
   stage_t        pipe [RD_LAT];
   logic [DATA_W-1:0] pix;
`ifdef VGA_TESTPAT_EN
   logic          pat0;
   logic [2:0]    bar0;
`endif

   vga_timing_gen #(
      .CH_NUM (CH_NUM),
      .H_SYNC (H_SYNC),
      .H_BACK (H_BACK),
      .H_DISP (H_DISP),
      .H_FRONT(H_FRONT),
      .V_SYNC (V_SYNC),
      .V_BACK (V_BACK),
      .V_DISP (V_DISP),
      .V_FRONT(V_FRONT)
   ) u_timing (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
`ifdef VGA_TESTPAT_EN
      .pat_on(pat_on),
      .pat0  (pat0),
      .bar0  (bar0),
`endif
      .hs0   (hs0),
      .vs0   (vs0),
      .de0   (de0),
      .sof0  (sof0),
      .idx0  (idx0),
      .ch_req(ch_req),
      .busy  (busy)
   );

   always_comb begin
      s0     = '0;
      s0.hs  = hs0;
      s0.vs  = vs0;
      s0.de  = de0;
      s0.sof = sof0;
      s0.idx = idx0;
`ifdef VGA_TESTPAT_EN
      s0.pat = pat0;
      s0.bar = bar0;
`endif
   end

   // NOTE: the delay line is reset because its de/sync bits drive outputs directly after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= s0;
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign sd = pipe[RD_LAT-1];

`ifdef VGA_TESTPAT_EN
   localparam int unsigned B_W = DATA_W / 3;
   localparam int unsigned G_W = DATA_W - 2 * B_W;
   localparam logic [DATA_W-1:0] B_MASK = DATA_W'((64'd1 << B_W) - 64'd1);
   localparam logic [DATA_W-1:0] G_MASK = DATA_W'(((64'd1 << G_W) - 64'd1) << B_W);
   localparam logic [DATA_W-1:0] R_MASK = DATA_W'(((64'd1 << B_W) - 64'd1) << (B_W + G_W));
   logic [2:0] rgb;
`endif

   always_comb begin
      pix = ch_din[int'(sd.idx) * DATA_W +: DATA_W];
`ifdef VGA_TESTPAT_EN
      rgb = bar_rgb(sd.bar);
      if (sd.pat) pix = (rgb[2] ? R_MASK : '0) | (rgb[1] ? G_MASK : '0) | (rgb[0] ? B_MASK : '0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hsync   <= ~HS_POL;
         vga_vsync   <= ~VS_POL;
         vga_de      <= 1'b0;
         vga_data    <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_hsync   <= sd.hs ? HS_POL : ~HS_POL;
         vga_vsync   <= sd.vs ? VS_POL : ~VS_POL;
         vga_de      <= sd.de;
         vga_data    <= sd.de ? pix : '0;
         frame_start <= sd.sof;
      end
   end

endmodule

// File: tb/tb_vga_multi_ch_driver.sv
// Directed bench: 16x7 raster, two channels, RD_LAT 2 main instance plus RD_LAT 1 and 4 instances.
module tb_vga_multi_ch_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        en_l = 1'b0;
   int          passed = 0;
   int          total = 0;

   logic [1:0]  ch_req;
   logic [31:0] ch_din;
   logic        vga_hsync, vga_vsync, vga_de, frame_start, busy;
   logic [15:0] vga_data;

   logic [1:0]  ch_req_l1, ch_req_l4;
   logic [31:0] ch_din_l1, ch_din_l4;
   logic        hs_l1, vs_l1, de_l1, fs_l1, busy_l1;
   logic        hs_l4, vs_l4, de_l4, fs_l4, busy_l4;
   logic [15:0] data_l1, data_l4;

   always #5 clk = ~clk;

   assign ch_din = {16'h5555, 16'hAAAA};

   vga_multi_ch_driver #(
      .DATA_W(16), .CH_NUM(2), .RD_LAT(2),
      .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .ch_req(ch_req), .ch_din(ch_din),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .vga_data(vga_data),
      .frame_start(frame_start), .busy(busy)
   );

   vga_multi_ch_driver #(
      .DATA_W(16), .CH_NUM(2), .RD_LAT(1),
      .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_l1 (
      .clk(clk), .rst_n(rst_n), .en(en_l), .ch_req(ch_req_l1), .ch_din(ch_din_l1),
      .vga_hsync(hs_l1), .vga_vsync(vs_l1), .vga_de(de_l1), .vga_data(data_l1),
      .frame_start(fs_l1), .busy(busy_l1)
   );

   vga_multi_ch_driver #(
      .DATA_W(16), .CH_NUM(2), .RD_LAT(4),
      .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_l4 (
      .clk(clk), .rst_n(rst_n), .en(en_l), .ch_req(ch_req_l4), .ch_din(ch_din_l4),
      .vga_hsync(hs_l4), .vga_vsync(vs_l4), .vga_de(de_l4), .vga_data(data_l4),
      .frame_start(fs_l4), .busy(busy_l4)
   );

   // Counting sources: each request returns the next count on the requested lane only,
   // exactly RD_LAT cycles later; other lanes carry a poison value.
   logic [15:0] cnt1, cnt4;
   logic [17:0] q1;
   logic [17:0] q4 [4];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt1 <= '0;
         q1   <= '0;
      end else begin
         q1 <= (ch_req_l1 != 2'b00) ? {1'b1, ch_req_l1[1], cnt1} : 18'd0;
         if (ch_req_l1 != 2'b00) cnt1 <= cnt1 + 16'd1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt4 <= '0;
         for (int i = 0; i < 4; i++) q4[i] <= '0;
      end else begin
         for (int i = 1; i < 4; i++) q4[i] <= q4[i-1];
         q4[0] <= (ch_req_l4 != 2'b00) ? {1'b1, ch_req_l4[1], cnt4} : 18'd0;
         if (ch_req_l4 != 2'b00) cnt4 <= cnt4 + 16'd1;
      end
   end

   assign ch_din_l1 = {(q1[17] && q1[16]) ? q1[15:0] : 16'hDEAD,
                       (q1[17] && !q1[16]) ? q1[15:0] : 16'hDEAD};
   assign ch_din_l4 = {(q4[3][17] && q4[3][16]) ? q4[3][15:0] : 16'hDEAD,
                       (q4[3][17] && !q4[3][16]) ? q4[3][15:0] : 16'hDEAD};

   // Reset, then raise the selected enable; returns at the edge that enters RUN,
   // so the following negedge is cycle 0 with the counters at (0,0).
   task automatic restart(input logic main);
      rst_n = 1'b0; en = 1'b0; en_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      if (main) en = 1'b1;
      else      en_l = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; en_l = 1'b0;
      @(negedge clk);
      total++; if (ch_req !== 2'b00)    $display("FAIL reset_ch_req: got %b want 00", ch_req); else passed++;
      total++; if (vga_de !== 1'b0)     $display("FAIL reset_de: got %b want 0", vga_de); else passed++;
      total++; if (vga_data !== 16'h0)  $display("FAIL reset_data: got %h want 0000", vga_data); else passed++;
      total++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start); else passed++;
      total++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (vga_hsync !== 1'b1)  $display("FAIL reset_hsync: got %b want 1", vga_hsync); else passed++;
      total++; if (vga_vsync !== 1'b1)  $display("FAIL reset_vsync: got %b want 1", vga_vsync); else passed++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0)       $display("FAIL idle_busy: got %b want 0", busy); else passed++;
      total++; if (vga_hsync !== 1'b1)  $display("FAIL idle_hsync: got %b want 1", vga_hsync); else passed++;
   endtask

   task automatic test_frame();
      int first_hs = -1, first_de = -1, first_req = -1, fs0 = -1, fs1 = -1;
      int de_cnt = 0, de_lines = 0, data_err = 0, idle_err = 0;
      int req0 = 0, req1 = 0, req_err = 0, busy_low = 0, pos = 0, rpos = 0;
      logic prev_de = 1'b0;
      logic [1:0] prev_req = 2'b00;
      restart(1'b1);
      for (int c = 0; c < 230; c++) begin
         @(negedge clk);
         if (vga_hsync === 1'b0 && first_hs < 0) first_hs = c;
         if (frame_start === 1'b1) begin
            if (fs0 < 0) fs0 = c;
            else if (fs1 < 0) fs1 = c;
         end
         if (busy !== 1'b1) busy_low++;
         if (vga_de === 1'b1) begin
            if (!prev_de) begin
               pos = 0;
               if (c < 115) de_lines++;
            end
            if (first_de < 0) first_de = c;
            if (c < 115) de_cnt++;
            if (vga_data !== ((pos < 4) ? 16'hAAAA : 16'h5555)) data_err++;
            pos++;
         end else if (vga_data !== 16'h0) begin
            idle_err++;
         end
         prev_de = vga_de;
         if (ch_req !== 2'b00) begin
            if (prev_req == 2'b00) rpos = 0;
            if (first_req < 0) first_req = c;
            if (c < 112) begin
               if (ch_req[0]) req0++;
               if (ch_req[1]) req1++;
            end
            if (ch_req !== ((rpos < 4) ? 2'b01 : 2'b10)) req_err++;
            rpos++;
         end
         prev_req = ch_req;
      end
      total++; if (first_hs != 3)  $display("FAIL first_hsync_cycle: got %0d want 3", first_hs); else passed++;
      total++; if (first_req != 38) $display("FAIL first_req_cycle: got %0d want 38", first_req); else passed++;
      total++; if (first_de != 41) $display("FAIL first_de_cycle: got %0d want 41", first_de); else passed++;
      total++; if (fs0 != 3)       $display("FAIL frame_start_first: got %0d want 3", fs0); else passed++;
      total++; if (fs1 != 115)     $display("FAIL frame_start_second: got %0d want 115", fs1); else passed++;
      total++; if (de_cnt != 32)   $display("FAIL de_count_frame: got %0d want 32", de_cnt); else passed++;
      total++; if (de_lines != 4)  $display("FAIL de_lines_frame: got %0d want 4", de_lines); else passed++;
      total++; if (data_err != 0)  $display("FAIL de_data_pattern: got %0d bad pixels want 0", data_err); else passed++;
      total++; if (idle_err != 0)  $display("FAIL data_outside_de: got %0d nonzero want 0", idle_err); else passed++;
      total++; if (req0 != 16)     $display("FAIL ch0_req_count: got %0d want 16", req0); else passed++;
      total++; if (req1 != 16)     $display("FAIL ch1_req_count: got %0d want 16", req1); else passed++;
      total++; if (req_err != 0)   $display("FAIL req_order: got %0d bad cycles want 0", req_err); else passed++;
      total++; if (busy_low != 0)  $display("FAIL busy_running: got %0d low cycles want 0", busy_low); else passed++;
   endtask

   task automatic test_stop();
      int de_cnt = 0, fs_cnt = 0, vs_cnt = 0, busy_fall = -1, late_active = 0;
      restart(1'b1);
      for (int c = 0; c < 140; c++) begin
         @(negedge clk);
         if (vga_de === 1'b1) de_cnt++;
         if (frame_start === 1'b1) fs_cnt++;
         if (vga_vsync === 1'b0) vs_cnt++;
         if (busy === 1'b0 && busy_fall < 0) busy_fall = c;
         if (c >= 115 && (vga_de !== 1'b0 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1 ||
                          frame_start !== 1'b0 || ch_req !== 2'b00 || vga_data !== 16'h0))
            late_active++;
         if (c == 35) en = 1'b0;
      end
      total++; if (de_cnt != 32)    $display("FAIL stop_de_count: got %0d want 32", de_cnt); else passed++;
      total++; if (fs_cnt != 1)     $display("FAIL stop_fs_count: got %0d want 1", fs_cnt); else passed++;
      total++; if (vs_cnt != 16)    $display("FAIL stop_vsync_count: got %0d want 16", vs_cnt); else passed++;
      total++; if (busy_fall != 112) $display("FAIL stop_busy_fall: got %0d want 112", busy_fall); else passed++;
      total++; if (late_active != 0) $display("FAIL stop_outputs_inactive: got %0d active cycles want 0", late_active); else passed++;
   endtask

   task automatic test_toggle();
      int fs [3] = '{-1, -1, -1};
      int nfs = 0, busy_low = 0, de_cnt = 0;
      restart(1'b1);
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         if (frame_start === 1'b1 && nfs < 3) begin
            fs[nfs] = c;
            nfs++;
         end
         if (busy !== 1'b1) busy_low++;
         if (vga_de === 1'b1 && c < 230) de_cnt++;
         if (c == 20) en = 1'b0;
         if (c == 50) en = 1'b1;
      end
      total++; if (fs[0] != 3)   $display("FAIL toggle_fs0: got %0d want 3", fs[0]); else passed++;
      total++; if (fs[1] != 115) $display("FAIL toggle_fs1: got %0d want 115", fs[1]); else passed++;
      total++; if (fs[2] != 227) $display("FAIL toggle_fs2: got %0d want 227", fs[2]); else passed++;
      total++; if (busy_low != 0) $display("FAIL toggle_busy: got %0d low cycles want 0", busy_low); else passed++;
      total++; if (de_cnt != 64) $display("FAIL toggle_de_count: got %0d want 64", de_cnt); else passed++;
   endtask

   task automatic test_reset_mid();
      int first_fs = -1, first_de = -1;
      restart(1'b1);
      repeat (46) @(negedge clk);
      total++; if (vga_de !== 1'b1)    $display("FAIL mid_de_before: got %b want 1", vga_de); else passed++;
      total++; if (ch_req !== 2'b10)   $display("FAIL mid_req_before: got %b want 10", ch_req); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (vga_de !== 1'b0)    $display("FAIL mid_de: got %b want 0", vga_de); else passed++;
      total++; if (vga_data !== 16'h0) $display("FAIL mid_data: got %h want 0000", vga_data); else passed++;
      total++; if (ch_req !== 2'b00)   $display("FAIL mid_req: got %b want 00", ch_req); else passed++;
      total++; if (busy !== 1'b0)      $display("FAIL mid_busy: got %b want 0", busy); else passed++;
      total++; if (vga_hsync !== 1'b1 || vga_vsync !== 1'b1)
         $display("FAIL mid_sync: got hs=%b vs=%b want 1 1", vga_hsync, vga_vsync); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (frame_start === 1'b1 && first_fs < 0) first_fs = c;
         if (vga_de === 1'b1 && first_de < 0) first_de = c;
      end
      total++; if (first_fs != 3)  $display("FAIL mid_restart_fs: got %0d want 3", first_fs); else passed++;
      total++; if (first_de != 41) $display("FAIL mid_restart_de: got %0d want 41", first_de); else passed++;
   endtask

   task automatic test_latency();
      int k1 = 0, k4 = 0, err1 = 0, err4 = 0;
      logic b1 = 1'b0, b4 = 1'b0;
      restart(1'b0);
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         if (c == 10) begin
            b1 = busy_l1;
            b4 = busy_l4;
         end
         if (de_l1 === 1'b1) begin
            if (data_l1 !== 16'(k1)) err1++;
            k1++;
         end
         if (de_l4 === 1'b1) begin
            if (data_l4 !== 16'(k4)) err4++;
            k4++;
         end
      end
      en_l = 1'b0;
      total++; if (b1 !== 1'b1) $display("FAIL lat1_busy: got %b want 1", b1); else passed++;
      total++; if (b4 !== 1'b1) $display("FAIL lat4_busy: got %b want 1", b4); else passed++;
      total++; if (k1 != 32)   $display("FAIL lat1_pixel_count: got %0d want 32", k1); else passed++;
      total++; if (err1 != 0)  $display("FAIL lat1_sequence: got %0d bad pixels want 0", err1); else passed++;
      total++; if (k4 != 32)   $display("FAIL lat4_pixel_count: got %0d want 32", k4); else passed++;
      total++; if (err4 != 0)  $display("FAIL lat4_sequence: got %0d bad pixels want 0", err4); else passed++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passed, total);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_frame();
      test_stop();
      test_toggle();
      test_reset_mid();
      test_latency();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
